// File: rtl/rr_reg_write_sched_pkg.sv
// Shared definitions for the round-robin register write scheduler:
// FSM state encoding, write-counter width and an index-width helper.
package rr_reg_write_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int WR_COUNT_W = 8;

    // A single requester still needs a one-bit index to keep port widths legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_reg_write_sched_rr_pick.sv
// Combinational circular priority picker: finds the first set request bit
// at or after ptr_i, wrapping from NREQ-1 back to 0.
module rr_pick
    import rr_reg_write_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            found_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the loop can leave it unassigned and infer a latch.
        idx_o   = '0;
        found_o = 1'b0;
        // Scanning from the farthest offset down lets the nearest hit win.
        for (int k = NREQ - 1; k >= 0; k--) begin
            int cand;
            cand = (int'(ptr_i) + k) % NREQ;
            if (req_i[cand]) begin
                idx_o   = IW'(cand);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_reg_write_sched.sv
// Round-robin scheduler sharing one WIDTH-bit register among NREQ requesters:
// IDLE arbitrates, GRANT captures the winner's data, WRITE commits and acks.
module rr_reg_write_sched
    import rr_reg_write_sched_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic [WR_COUNT_W-1:0]   wr_count
);

    localparam int IW = idx_width(NREQ);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [NREQ-1:0]         ack_q, ack_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic [WR_COUNT_W-1:0]   cnt_q, cnt_d;

    logic [IW-1:0]           pick_idx;
    logic                    pick_found;
    logic [WIDTH-1:0]        sel_data;
    logic [IW-1:0]           ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Mux the granted requester's data slice out of the flat bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx_q == IW'(i)) begin
                sel_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        data_d  = data_q;
        value_d = value_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped request aborts cleanly: pointer stays, nothing commits.
                if (req[idx_q]) begin
                    data_d  = sel_data;
                    ack_d   = gnt_q;
                    state_d = ST_WRITE;
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                value_d = data_q;
                cnt_d   = cnt_q + WR_COUNT_W'(1);
                ptr_d   = ptr_next;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            value_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign value    = value_q;
    assign busy     = (state_q != ST_IDLE);
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_rr_reg_write_sched.sv
// Self-checking bench for rr_reg_write_sched: directed scenarios followed by
// randomized requester traffic, compared against a transaction-timing model.
module tb_rr_reg_write_sched;

    localparam int         N  = 4;
    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'h3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]  gnt, ack;
    logic [W-1:0]  value;
    logic          busy;
    logic [7:0]    wr_count;

    rr_reg_write_sched #(.NREQ(N), .WIDTH(W), .RESET_VAL(RV)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .value    (value),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Requester agents
    logic [N-1:0] pend = '0;
    logic [W-1:0] pdata [N];
    logic         sticky = 1'b0;
    logic         rnd = 1'b0;
    logic         rst_in = 1'b1;

    // Reference model: one transaction at a time, tracked by its start cycle
    int         cyc = 0;
    int         t_start = -10;
    int         arb_ok = 0;
    int         w = 0;
    int         m_ptr = 0;
    int         m_writes = 0;
    logic       aborted = 1'b0;
    logic [3:0] cap = '0;
    logic [3:0] m_value = RV;
    logic [7:0] m_count = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] prev_gnt = '0, prev_ack = '0;
    logic [7:0]   prev_cnt = '0;
    logic         wrap_seen = 1'b0;
    int           ack_log[$];
    int           val_log[$];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic       in_g;
        logic [3:0] e_gnt, e_ack;
        reset = rst_in;
        req   = pend;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = pdata[i];

        if (!rst_in) begin
            if (cyc == t_start + 1 && !aborted) begin
                if (!pend[w]) begin
                    aborted = 1'b1;
                    arb_ok  = cyc + 1;
                end else begin
                    cap = pdata[w];
                end
            end
            if (cyc >= arb_ok && pend != '0) begin
                w       = pick(pend, m_ptr);
                t_start = cyc;
                aborted = 1'b0;
                arb_ok  = cyc + 3;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;

        if (rst_in) begin
            m_value = RV;
            m_count = '0;
            m_ptr   = 0;
            t_start = -10;
            arb_ok  = cyc;
            aborted = 1'b0;
        end else if (cyc == t_start + 3 && !aborted) begin
            m_value = cap;
            m_count = m_count + 8'd1;
            m_ptr   = (w + 1) % N;
            m_writes++;
        end

        in_g  = (cyc == t_start + 1) || (cyc == t_start + 2 && !aborted);
        e_gnt = in_g ? 4'(1 << w) : 4'h0;
        e_ack = (cyc == t_start + 2 && !aborted) ? 4'(1 << w) : 4'h0;

        chk("gnt", gnt, e_gnt);
        chk("ack", ack, e_ack);
        chk("busy", busy, in_g);
        chk("value", value, m_value);
        chk("wr_count", wr_count, m_count);
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        chk("ack_onehot0", 32'($onehot0(ack)), 1);
        chk("ack_after_gnt", ack & ~prev_gnt, 0);

        if (prev_ack != '0) val_log.push_back(int'(value));
        if (ack != '0) ack_log.push_back($clog2(ack));
        if (prev_cnt == 8'hFF && wr_count == 8'h00) wrap_seen = 1'b1;
        prev_gnt = gnt;
        prev_ack = ack;
        prev_cnt = wr_count;

        if (e_ack != '0 && !sticky) pend[w] = 1'b0;
        if (rnd) begin
            if (cyc == t_start + 1 && !aborted && $urandom_range(7) == 0) pend[w] = 1'b0;
            if (cyc == t_start + 2 && !aborted) pdata[w] = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 4'($urandom);
                end
            end
        end
    endtask

    initial begin
        int saved_cnt;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        reset = 1'b1;
        req   = '0;
        wdata = '0;

        // 1: reset held two cycles, then one quiet cycle
        rst_in = 1'b1;
        cycle();
        cycle();
        rst_in = 1'b0;
        cycle();
        chk("t1_value", value, RV);
        chk("t1_gnt", gnt, 0);
        chk("t1_ack", ack, 0);
        chk("t1_wr_count", wr_count, 0);
        chk("t1_busy", busy, 0);

        // 2: single request, latency check
        pend     = 4'b0001;
        pdata[0] = 4'h5;
        cycle();
        chk("t2_gnt_c1", gnt, 4'b0001);
        cycle();
        chk("t2_ack_c2", ack, 4'b0001);
        cycle();
        chk("t2_value_c3", value, 4'h5);
        chk("t2_wr_count", wr_count, 1);

        // 3: all four held continuously, from a fresh pointer
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        ack_log.delete();
        val_log.delete();
        sticky = 1'b1;
        pend   = 4'b1111;
        for (int i = 0; i < N; i++) pdata[i] = 4'(i + 1);
        for (int k = 0; k < 15; k++) cycle();
        sticky = 1'b0;
        pend   = '0;
        cycle();
        chk("t3_ack_count", ack_log.size(), 5);
        chk("t3_val_count", val_log.size(), 5);
        for (int k = 0; k < 5 && k < ack_log.size() && k < val_log.size(); k++) begin
            chk("t3_ack_order", ack_log[k], k % 4);
            chk("t3_value_seq", val_log[k], (k % 4) + 1);
        end

        // 4: requester 2 granted, then drops in GRANT; pointer must not move
        saved_cnt = int'(wr_count);
        pend      = 4'b0100;
        pdata[2]  = 4'h7;
        cycle();
        chk("t4_gnt", gnt, 4'b0100);
        pend[2] = 1'b0;
        cycle();
        chk("t4_abort_gnt", gnt, 0);
        chk("t4_abort_ack", ack, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_value_kept", value, 4'h1);
        chk("t4_count_kept", wr_count, saved_cnt);
        pend     = 4'b0101;
        pdata[0] = 4'h9;
        pdata[2] = 4'h6;
        cycle();
        chk("t4_regrant_from_ptr", gnt, 4'b0100);
        for (int k = 0; k < 20 && (pend != '0 || cyc < arb_ok); k++) cycle();
        chk("t4_drained", pend, 0);
        chk("t4_final_value", value, 4'h9);

        // 5: reset lands during WRITE of 4'hA
        pend     = 4'b0010;
        pdata[1] = 4'hA;
        cycle();
        cycle();
        chk("t5_ack_in_write", ack, 4'b0010);
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        chk("t5_value_reset", value, RV);
        chk("t5_ack_cleared", ack, 0);
        chk("t5_count_reset", wr_count, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_no_A", value == 4'hA, 0);
        end

        // 6: randomized traffic across the wr_count wrap
        m_writes = 0;
        rnd      = 1'b1;
        for (int k = 0; k < 4000 && m_writes < 260; k++) cycle();
        rnd  = 1'b0;
        pend = '0;
        for (int k = 0; k < 6; k++) cycle();
        chk("t6_write_budget", m_writes >= 260, 1);
        chk("t6_wrap_seen", wrap_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
